data_path: RTL and testbench

Single-cycle register-file plus ALU datapath for the 32-bit RISC core.
- Decodes register indices, opcode and literal from a 32-bit instruction word.
- Reads two source registers, computes an ALU result, and writes the result or an external data word back to a destination register on the clock edge.
- Sits between the instruction register / memory interface and the control unit, which drives the write enable and the write-source select.

---
 rtl/data_path_if.sv | 21 ++
 rtl/data_path.sv | 58 +++++
 tb/tb_data_path.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/data_path_if.sv
// data_path_if: instruction/write-back/read bus between control logic and the data_path register file + ALU
// Ports (signals): irInput, dataInput, wEn, registerFileSelect driven by master; aluOut, raData, rbData driven by slave
interface data_path_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] irInput;
   logic [WIDTH-1:0] dataInput;
   logic             wEn;
   logic             registerFileSelect;
   logic [WIDTH-1:0] aluOut;
   logic [WIDTH-1:0] raData;
   logic [WIDTH-1:0] rbData;
   modport master (
      output irInput, dataInput, wEn, registerFileSelect,
      input  aluOut, raData, rbData
   );
   modport slave (
      input  irInput, dataInput, wEn, registerFileSelect,
      output aluOut, raData, rbData
   );
endinterface

// File: rtl/data_path.sv
// data_path: 32 x WIDTH register file (2 async reads, 1 sync write) feeding a combinational ALU
// Ports: clk; rst (async, active-high, clears all registers); bus (data_path_if.slave):
//   irInput, dataInput, wEn, registerFileSelect in; aluOut, raData, rbData out
// Optional: define DATAPATH_CMP_EN to add CMPEQ/CMPLT/CMPLE opcodes (0100/0101/0110)
module data_path #(
   parameter int WIDTH = 32
) (
   input logic        clk,
   input logic        rst,
   data_path_if.slave bus
);
   logic [4:0]       rc, ra, rb;
   logic [3:0]       op;
   logic [WIDTH-1:0] a, b, alu, wb;
   logic [WIDTH-1:0] regs_q [32];
   logic [WIDTH-1:0] regs_d [32];
   logic             unused_ir;
   assign unused_ir = bus.irInput[31];
   assign op = bus.irInput[29:26];
   assign rc = bus.irInput[25:21];
   assign ra = bus.irInput[20:16];
   assign rb = bus.irInput[15:11];
   // Entry 31 is never written and only cleared by reset, so it always reads 0.
   assign a  = regs_q[ra];
   assign b  = bus.irInput[30] ? {{(WIDTH-16){bus.irInput[15]}}, bus.irInput[15:0]} : regs_q[rb];
   always_comb begin
      alu = '0;
      case (op)
         4'b0000: alu = a + b;
         4'b0001: alu = a - b;
`ifdef DATAPATH_CMP_EN
         4'b0100: alu = {{(WIDTH-1){1'b0}}, a == b};
         4'b0101: alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         4'b0110: alu = {{(WIDTH-1){1'b0}}, $signed(a) <= $signed(b)};
`endif
         4'b1000: alu = a & b;
         4'b1001: alu = a | b;
         4'b1010: alu = a ^ b;
         4'b1011: alu = ~(a ^ b);
         4'b1100: alu = a << b[4:0];
         4'b1101: alu = a >> b[4:0];
         4'b1110: alu = $signed(a) >>> b[4:0];
         default: alu = '0;
      endcase
   end
   assign wb = bus.registerFileSelect ? bus.dataInput : alu;
   always_comb begin
      regs_d = regs_q;
      if (bus.wEn && rc != 5'd31) regs_d[rc] = wb;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) regs_q <= '{default: '0};
      else     regs_q <= regs_d;
   end
   assign bus.aluOut = alu;
   assign bus.raData = a;
   assign bus.rbData = regs_q[rb];
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed plan checks plus randomized stimulus against a behavioural register-file/ALU model
module tb_data_path;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] m [32];
   data_path_if #(.WIDTH(32)) bus ();
   data_path #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [31:0] ins(bit l, logic [3:0] op, logic [4:0] rc, logic [4:0] ra, logic [15:0] low);
      return {1'b0, l, op, rc, ra, low};
   endfunction
   function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      int unsigned s;
      s = b % 32;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
`ifdef DATAPATH_CMP_EN
         4'd4:  return (a == b) ? 32'd1 : 32'd0;
         4'd5:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd6:  return (int'(a) <= int'(b)) ? 32'd1 : 32'd0;
`endif
         4'd8:  return a & b;
         4'd9:  return a | b;
         4'd10: return a ^ b;
         4'd11: return ~(a ^ b);
         4'd12: return a << s;
         4'd13: return a >> s;
         4'd14: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
         default: return 32'd0;
      endcase
   endfunction
   function automatic logic [31:0] ref_b(logic [31:0] ir);
      return ir[30] ? {{16{ir[15]}}, ir[15:0]} : m[ir[15:11]];
   endfunction
   function automatic logic [31:0] ref_out(logic [31:0] ir);
      return ref_alu(ir[29:26], m[ir[20:16]], ref_b(ir));
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask
   always @(posedge clk or posedge rst) begin
      if (rst) for (int i = 0; i < 32; i++) m[i] <= 32'd0;
      else if (bus.wEn && bus.irInput[25:21] != 5'd31)
         m[bus.irInput[25:21]] <= bus.registerFileSelect ? bus.dataInput : ref_out(bus.irInput);
   end
   always @(negedge clk) begin
      if (!rst) begin
         chk("raData", bus.raData, m[bus.irInput[20:16]]);
         chk("rbData", bus.rbData, m[bus.irInput[15:11]]);
         chk("aluOut", bus.aluOut, ref_out(bus.irInput));
      end
   end
   task automatic drive(input logic [31:0] ir, input logic [31:0] din, input logic we, input logic sel);
      @(negedge clk);
      #1;
      bus.irInput = ir;
      bus.dataInput = din;
      bus.wEn = we;
      bus.registerFileSelect = sel;
      @(posedge clk);
      #1;
   endtask
   task automatic rd(input string name, input logic [4:0] r, input logic [31:0] exp);
      @(negedge clk);
      #1;
      bus.irInput = ins(1'b0, 4'd0, 5'd31, r, {r, 11'd0});
      bus.wEn = 1'b0;
      #1;
      chk(name, bus.raData, exp);
   endtask
   task automatic wr(input logic [4:0] r, input logic [31:0] v);
      drive(ins(1'b0, 4'd0, r, 5'd0, 16'd0), v, 1'b1, 1'b1);
   endtask
   task automatic op(input bit l, input logic [3:0] o, input logic [4:0] rc, input logic [4:0] ra, input logic [15:0] low);
      drive(ins(l, o, rc, ra, low), 32'hDEAD_BEEF, 1'b1, 1'b0);
   endtask
   initial begin
      bus.irInput = ins(1'b0, 4'd0, 5'd0, 5'd4, {5'd7, 11'd0});
      bus.dataInput = 32'd0;
      bus.wEn = 1'b1;
      bus.registerFileSelect = 1'b1;
      @(negedge clk);
      #1;
      chk("reset_ra", bus.raData, 32'd0);
      chk("reset_alu", bus.aluOut, 32'd0);
      bus.wEn = 1'b0;
      rst = 1'b0;
      wr(4, 4); wr(7, 7); wr(1, 1); wr(3, 3); wr(2, 2); wr(8, 8); wr(9, 9); wr(16, 32'h8000_0000);
      rd("r4", 4, 4); rd("r7", 7, 7); rd("r1", 1, 1); rd("r3", 3, 3);
      rd("r2", 2, 2); rd("r8", 8, 8); rd("r9", 9, 9); rd("r16", 16, 32'h8000_0000);
      op(0, 4'd0,  11, 4, {5'd7, 11'd0});  rd("add", 11, 32'd11);
      op(0, 4'd1,  12, 2, {5'd1, 11'd0});  rd("sub", 12, 32'd1);
      op(0, 4'd8,  13, 3, {5'd1, 11'd0});  rd("and", 13, 32'd1);
      op(0, 4'd9,  14, 3, {5'd8, 11'd0});  rd("or", 14, 32'hB);
      op(0, 4'd10, 15, 9, {5'd7, 11'd0});  rd("xor", 15, 32'hE);
      op(0, 4'd11, 17, 9, {5'd7, 11'd0});  rd("xnor", 17, 32'hFFFF_FFF1);
      op(0, 4'd12, 18, 2, {5'd1, 11'd0});  rd("shl", 18, 32'd4);
      op(0, 4'd13, 19, 2, {5'd1, 11'd0});  rd("shr", 19, 32'd1);
      op(0, 4'd14, 20, 16, {5'd1, 11'd0}); rd("sra", 20, 32'hC000_0000);
      op(1, 4'd0,  21, 4, 16'd1);          rd("addi", 21, 32'd5);
      op(1, 4'd1,  22, 2, 16'd1);          rd("subi", 22, 32'd1);
      op(1, 4'd9,  23, 3, 16'd8);          rd("ori", 23, 32'hB);
      op(1, 4'd1,  24, 2, 16'hFFFF);       rd("subi_sext", 24, 32'd3);
      op(1, 4'd0,  4, 4, 16'd1);           rd("self_inc", 4, 32'd5);
      drive(ins(1'b1, 4'd0, 5'd7, 5'd9, 16'd100), 32'd77, 1'b0, 1'b1);
      rd("wen0", 7, 32'd7);
      wr(31, 32'd5);
      rd("r31", 31, 32'd0);
      @(negedge clk);
      #1;
      bus.irInput = ins(1'b0, 4'd5, 5'd31, 5'd16, {5'd1, 11'd0});
      #1;
`ifdef DATAPATH_CMP_EN
      chk("cmplt", bus.aluOut, 32'd1);
`else
      chk("cmp_off", bus.aluOut, 32'd0);
`endif
      drive(ins(1'b0, 4'd0, 5'd4, 5'd4, {5'd7, 11'd0}), 32'd55, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_ra", bus.raData, 32'd0);
      chk("async_rst_rb", bus.rbData, 32'd0);
      @(posedge clk);
      #1;
      bus.wEn = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_blocks_write", bus.raData, 32'd0);
      for (int i = 0; i < 300; i++)
         drive($urandom, $urandom, 1'($urandom), 1'($urandom));
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
